// File: rtl/hilo_ctrl.sv
// HI/LO register owner and issue controller for the multi-cycle mul/div units.
// Operands are latched at issue and the result is captured on the cycle the unit drops its stall.
module hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] rd_data,
    output logic        pipe_stall,
    output logic        busy,
    output logic        mul_req,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_stall,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        div_req,
    output logic [31:0] div_dvsr,
    output logic [31:0] div_dvnd,
    input  logic        div_stall,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo
);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_MFHI = 3'd2;
    localparam logic [2:0] OP_MFLO = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, GAP} state_t;

    state_t      state_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] opa_reg;
    logic [31:0] opb_reg;
    logic        mul_req_reg;
    logic        div_req_reg;

    logic op_known;
    logic op_is_mf;
    logic accept;

    assign op_known = op_valid && (op_code <= OP_MTLO);
    assign op_is_mf = (op_code == OP_MFHI) || (op_code == OP_MFLO);
    // HI/LO are already final in GAP, so only moves-from may proceed there.
    assign pipe_stall = op_known && (state_reg != IDLE) && !((state_reg == GAP) && op_is_mf);
    assign accept     = op_known && (state_reg == IDLE);

    assign rd_data  = (op_code == OP_MFLO) ? lo_reg : hi_reg;
    assign busy     = (state_reg != IDLE);
    assign mul_req  = mul_req_reg;
    assign div_req  = div_req_reg;
    assign mul_a    = opa_reg;
    assign mul_b    = opb_reg;
    assign div_dvsr = opa_reg;
    assign div_dvnd = opb_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            hi_reg      <= '0;
            lo_reg      <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            mul_req_reg <= 1'b0;
            div_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        case (op_code)
                            OP_MULT: begin
                                opa_reg     <= rs_val;
                                opb_reg     <= rt_val;
                                mul_req_reg <= 1'b1;
                                state_reg   <= MUL_RUN;
                            end
                            OP_DIV: begin
                                opa_reg     <= rt_val;
                                opb_reg     <= rs_val;
                                div_req_reg <= 1'b1;
                                state_reg   <= DIV_RUN;
                            end
                            OP_MTHI: hi_reg <= rs_val;
                            OP_MTLO: lo_reg <= rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL_RUN: begin
                    if (!mul_stall) begin
                        hi_reg      <= mul_hi;
                        lo_reg      <= mul_lo;
                        mul_req_reg <= 1'b0;
                        state_reg   <= GAP;
                    end
                end
                DIV_RUN: begin
                    if (!div_stall) begin
                        hi_reg      <= div_hi;
                        lo_reg      <= div_lo;
                        div_req_reg <= 1'b0;
                        state_reg   <= GAP;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
